// File: rtl/wb_mem_router.sv
// Routes a single Wishbone CPU bus onto ROM, RAM, peripheral channels and a status register.
// One transaction is in flight at a time; peripheral accesses are bounded by an ack timeout.
//
// state    | meaning
// IDLE     | waiting for a request, stall low
// MEM      | ROM/RAM strobe on the memory port
// MEM_DATA | capture memory read data
// P_REQ    | peripheral cyc/stb raised, waiting for the channel to accept
// P_WAIT   | stb accepted, cyc held until ack or timeout
// RESP     | single-cycle ack to the CPU
module wb_mem_router #(
  parameter int                        CPU_DATA_WIDTH = 8,
  parameter int                        CPU_ADDR_WIDTH = 16,
  parameter int                        ROM_ADDR_WIDTH = 14,
  parameter int                        RAM_ADDR_WIDTH = 15,
  parameter logic [CPU_ADDR_WIDTH-1:0] ROM_ADDR_LIMIT = 16'h4000,
  parameter logic [CPU_ADDR_WIDTH-1:0] RAM_ADDR_LIMIT = 16'hA000,
  parameter logic [CPU_ADDR_WIDTH-1:0] PERIPH_BASE    = 16'hA000,
  parameter int                        NUM_PERIPH     = 4,
  parameter logic [7:0]                TIMEOUT_CYCLES = 8'd64
) (
  input  logic                               i_clk,
  input  logic                               i_reset_n,
  input  logic                               i_wb_cyc,
  input  logic                               i_wb_stb,
  input  logic                               i_wb_we,
  input  logic [CPU_ADDR_WIDTH-1:0]          i_wb_addr,
  input  logic [CPU_DATA_WIDTH-1:0]          i_wb_data,
  output logic                               o_wb_ack,
  output logic                               o_wb_stall,
  output logic [CPU_DATA_WIDTH-1:0]          o_wb_data,
  output logic [ROM_ADDR_WIDTH-1:0]          o_rom_addr,
  output logic                               o_rom_stb,
  input  logic [CPU_DATA_WIDTH-1:0]          i_rom_data,
  output logic [RAM_ADDR_WIDTH-1:0]          o_ram_addr,
  output logic                               o_ram_stb,
  output logic                               o_ram_wr,
  output logic [CPU_DATA_WIDTH-1:0]          o_ram_data,
  input  logic [CPU_DATA_WIDTH-1:0]          i_ram_data,
  output logic [NUM_PERIPH-1:0]              o_p_cyc,
  output logic [NUM_PERIPH-1:0]              o_p_stb,
  output logic                               o_p_we,
  output logic [CPU_DATA_WIDTH-1:0]          o_p_data,
  input  logic [NUM_PERIPH*CPU_DATA_WIDTH-1:0] i_p_data,
  input  logic [NUM_PERIPH-1:0]              i_p_ack,
  input  logic [NUM_PERIPH-1:0]              i_p_stall
);

  typedef enum logic [2:0] {
    S_IDLE, S_MEM, S_MEM_DATA, S_P_REQ, S_P_WAIT, S_RESP
  } state_e;

  typedef enum logic [2:0] {
    T_ROM, T_RAM, T_PERIPH, T_STATUS, T_UNMAPPED
  } target_e;

  state_e                    state;
  target_e                   tgt;
  logic [CPU_ADDR_WIDTH-1:0] p_off;
  logic [NUM_PERIPH-1:0]     p_sel;
  logic                      accept, in_p, p_ack, p_stall, tmo_hit;
  logic [CPU_DATA_WIDTH-1:0] p_rdata;
  logic [7:0]                tmo_cnt;
  logic [2:0]                status, st_set, st_clr;
  logic                      req_we, req_rom;

  always_comb begin
    p_off = i_wb_addr - PERIPH_BASE;
    p_sel = NUM_PERIPH'(1) << p_off;
    if (i_wb_addr < ROM_ADDR_LIMIT) tgt = T_ROM;
    else if (i_wb_addr < RAM_ADDR_LIMIT) tgt = T_RAM;
    else if (i_wb_addr >= PERIPH_BASE && p_off < CPU_ADDR_WIDTH'(NUM_PERIPH)) tgt = T_PERIPH;
    else if (i_wb_addr >= PERIPH_BASE && p_off == CPU_ADDR_WIDTH'(NUM_PERIPH)) tgt = T_STATUS;
    else tgt = T_UNMAPPED;
  end

  // o_p_cyc only ever has the addressed bit set, so it doubles as the channel select
  always_comb begin
    p_ack   = |(i_p_ack & o_p_cyc);
    p_stall = |(i_p_stall & o_p_stb);
    p_rdata = '0;
    for (int i = 0; i < NUM_PERIPH; i++)
      if (o_p_cyc[i]) p_rdata = i_p_data[i*CPU_DATA_WIDTH +: CPU_DATA_WIDTH];
  end

  assign accept  = (state == S_IDLE) && i_wb_cyc && i_wb_stb;
  assign in_p    = (state == S_P_REQ) || (state == S_P_WAIT);
  // the count reaches TIMEOUT_CYCLES on this edge, so cyc is high for exactly TIMEOUT_CYCLES cycles
  assign tmo_hit = in_p && i_wb_cyc && !p_ack && (tmo_cnt == TIMEOUT_CYCLES - 8'd1);

  always_comb begin
    st_set = '0;
    st_clr = '0;
    if (accept) begin
      case (tgt)
        T_ROM:      st_set[1] = i_wb_we;
        T_STATUS:   if (i_wb_we) st_clr = i_wb_data[2:0];
        T_UNMAPPED: st_set[2] = 1'b1;
        default:    ;
      endcase
    end
    if (tmo_hit) st_set[0] = 1'b1;
  end

  always_ff @(posedge i_clk) begin
    if (!i_reset_n) begin
      state      <= S_IDLE;
      o_wb_ack   <= 1'b0;
      o_wb_stall <= 1'b0;
      o_wb_data  <= '0;
      o_rom_addr <= '0;
      o_rom_stb  <= 1'b0;
      o_ram_addr <= '0;
      o_ram_stb  <= 1'b0;
      o_ram_wr   <= 1'b0;
      o_ram_data <= '0;
      o_p_cyc    <= '0;
      o_p_stb    <= '0;
      o_p_we     <= 1'b0;
      o_p_data   <= '0;
      status     <= '0;
      tmo_cnt    <= '0;
      req_we     <= 1'b0;
      req_rom    <= 1'b0;
    end else begin
      o_wb_ack  <= 1'b0;
      o_rom_stb <= 1'b0;
      o_ram_stb <= 1'b0;
      o_ram_wr  <= 1'b0;
      status    <= (status & ~st_clr) | st_set;
      if (state != S_IDLE && !i_wb_cyc) begin
        state      <= S_IDLE;
        o_wb_stall <= 1'b0;
        o_p_cyc    <= '0;
        o_p_stb    <= '0;
      end else begin
        case (state)
          S_IDLE: if (accept) begin
            o_wb_stall <= 1'b1;
            req_we     <= i_wb_we;
            req_rom    <= (tgt == T_ROM);
            case (tgt)
              T_ROM: begin
                o_rom_addr <= i_wb_addr[ROM_ADDR_WIDTH-1:0];
                if (i_wb_we) begin
                  o_wb_ack <= 1'b1;
                  state    <= S_RESP;
                end else begin
                  o_rom_stb <= 1'b1;
                  state     <= S_MEM;
                end
              end
              T_RAM: begin
                o_ram_addr <= RAM_ADDR_WIDTH'(i_wb_addr - ROM_ADDR_LIMIT);
                o_ram_stb  <= 1'b1;
                o_ram_wr   <= i_wb_we;
                o_ram_data <= i_wb_data;
                state      <= S_MEM;
              end
              T_PERIPH: begin
                o_p_cyc  <= p_sel;
                o_p_stb  <= p_sel;
                o_p_we   <= i_wb_we;
                o_p_data <= i_wb_data;
                tmo_cnt  <= '0;
                state    <= S_P_REQ;
              end
              T_STATUS: begin
                if (!i_wb_we) o_wb_data <= CPU_DATA_WIDTH'(status);
                o_wb_ack <= 1'b1;
                state    <= S_RESP;
              end
              default: begin
                if (!i_wb_we) o_wb_data <= '1;
                o_wb_ack <= 1'b1;
                state    <= S_RESP;
              end
            endcase
          end
          S_MEM: begin
            if (req_we) begin
              o_wb_ack <= 1'b1;
              state    <= S_RESP;
            end else begin
              state <= S_MEM_DATA;
            end
          end
          S_MEM_DATA: begin
            o_wb_data <= req_rom ? i_rom_data : i_ram_data;
            o_wb_ack  <= 1'b1;
            state     <= S_RESP;
          end
          S_P_REQ, S_P_WAIT: begin
            if (p_ack) begin
              o_wb_data <= p_rdata;
              o_p_cyc   <= '0;
              o_p_stb   <= '0;
              o_wb_ack  <= 1'b1;
              state     <= S_RESP;
            end else if (tmo_hit) begin
              tmo_cnt   <= TIMEOUT_CYCLES;
              o_wb_data <= '1;
              o_p_cyc   <= '0;
              o_p_stb   <= '0;
              o_wb_ack  <= 1'b1;
              state     <= S_RESP;
            end else begin
              tmo_cnt <= tmo_cnt + 8'd1;
              if (state == S_P_REQ && !p_stall) begin
                o_p_stb <= '0;
                state   <= S_P_WAIT;
              end
            end
          end
          S_RESP: begin
            o_wb_stall <= 1'b0;
            state      <= S_IDLE;
          end
          default: state <= S_IDLE;
        endcase
      end
    end
  end

endmodule
